// File: rtl/regfile_2w2r_sb.sv
// Two-write, two-read register file with a per-register busy scoreboard.
// Reads are combinational with write-first bypass; port 1 wins same-address writes.
module regfile_2w2r_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              a_busy,
    output logic              b_busy,
    output logic              wr_coll
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_R0 != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_coll_q;
    logic              wr_coll_d;
    logic              w0_ok;
    logic              w1_ok;

    // A write only commits when it does not target the hardwired zero register.
    always_comb begin
        w0_ok = we0 && !(ZR && (waddr0 == '0));
        w1_ok = we1 && !(ZR && (waddr1 == '0));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (w0_ok) begin
            regs_d[waddr0] = wdata0;
            busy_d[waddr0] = 1'b0;
        end
        if (w1_ok) begin
            regs_d[waddr1] = wdata1;
            busy_d[waddr1] = 1'b0;
        end
        // Reserve is applied last: a new producer outranks the completing write.
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
        wr_coll_d = we0 && we1 && (waddr0 == waddr1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            wr_coll_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q    <= busy_d;
            wr_coll_q <= wr_coll_d;
        end
    end

    // Read port A: zero register, then port 1 bypass, then port 0 bypass, then storage.
    always_comb begin
        a_data = regs_q[a_addr];
        if (ZR && (a_addr == '0)) begin
            a_data = '0;
        end else if (!rst && w1_ok && (waddr1 == a_addr)) begin
            a_data = wdata1;
        end else if (!rst && w0_ok && (waddr0 == a_addr)) begin
            a_data = wdata0;
        end
    end

    always_comb begin
        b_data = regs_q[b_addr];
        if (ZR && (b_addr == '0)) begin
            b_data = '0;
        end else if (!rst && w1_ok && (waddr1 == b_addr)) begin
            b_data = wdata1;
        end else if (!rst && w0_ok && (waddr0 == b_addr)) begin
            b_data = wdata0;
        end
    end

    assign a_busy  = busy_q[a_addr];
    assign b_busy  = busy_q[b_addr];
    assign wr_coll = wr_coll_q;

endmodule
